// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, FSM states,
// field positions of the 7-bit memory/writeback control vector.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_AND   = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_SLL   = 3'd4,
    ALU_SRL   = 3'd5,
    ALU_MUL   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_t;

  // Bit positions inside mem_signals: {DataInSrc, MemRd, MemWr, NumOfByte[1:0], WBdata[1:0]}
  localparam int MEM_DATA_IN_SRC = 6;
  localparam int MEM_RD          = 5;
  localparam int MEM_WR          = 4;
  localparam int MEM_NUM_BYTE_HI = 3;
  localparam int MEM_NUM_BYTE_LO = 2;
  localparam int MEM_WB_DATA_HI  = 1;
  localparam int MEM_WB_DATA_LO  = 0;

  localparam logic [1:0] WB_PC  = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative shift-add multiplier (one partial product per clock, WIDTH steps).
// Only built when EX_MUL_EN is defined.
`ifdef EX_MUL_EN
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic               running_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_next;

  // The final step's sum is exposed combinationally so the caller can
  // register the product on the same edge that completes it.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = running_q && (count_q == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      count_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
    end else if (abort) begin
      running_q <= 1'b0;
      count_q   <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= {{WIDTH{1'b0}}, op_a};
      mplier_q  <= op_b;
    end else if (running_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
      if (done) running_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: ALU plus EX/MEM pipeline register. Defining EX_MUL_EN adds the
// iterative multiplier, the IDLE/MUL FSM and a live busy output.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             flush_in,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic [6:0]       mem_signals_in,
  input  logic [2:0]       rd_in,
  input  logic             reg_wr_in,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] imm_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] store_data,
  output logic [6:0]       mem_signals,
  output logic [2:0]       rd_out,
  output logic             reg_wr_out,
  output logic             zero_flag,
  output logic             carry_flag
);

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum_ext;

  logic             v_d, rw_d, z_d, c_d;
  logic [WIDTH-1:0] res_d, imm_d, pc_d, sd_d;
  logic [6:0]       mem_d;
  logic [2:0]       rd_d;

  assign accept = valid_in && !busy && !flush_in;

  // Single-cycle ALU. Without the multiplier, MUL falls through to a zero result.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    alu_res   = '0;
    alu_carry = 1'b0;
    sum_ext   = '0;
    case (alu_op_t'(alu_op))
      ALU_AND:   alu_res = op_a & op_b;
      ALU_ADD: begin
        sum_ext   = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      ALU_SUB: begin
        alu_res   = op_a - op_b;
        alu_carry = (op_a < op_b);
      end
      ALU_OR:    alu_res = op_a | op_b;
      ALU_SLL:   alu_res = op_a << op_b[3:0];
      ALU_SRL:   alu_res = op_a >> op_b[3:0];
      ALU_MUL:   alu_res = '0;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_t          state_q, state_d;
  logic               mul_start;
  logic               mul_done;
  logic               mul_emit;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   hold_imm, hold_pc, hold_sd;
  logic [6:0]         hold_mem;
  logic [2:0]         hold_rd;
  logic               hold_rw;

  assign is_mul = (alu_op_t'(alu_op) == ALU_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (flush_in),
    .op_a    (op_a),
    .op_b    (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: if (accept && is_mul) begin
        state_d   = MUL;
        mul_start = 1'b1;
      end
      MUL:  if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A branch redirect kills the multiply even on its final step.
    if (flush_in) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: these holding registers carry no reset; they are only read after
  // mul_start has loaded them, so reset would add routing with no benefit.
  always_ff @(posedge clk) begin
    if (mul_start) begin
      hold_imm <= imm_in;
      hold_pc  <= pc_in;
      hold_sd  <= store_data_in;
      hold_mem <= mem_signals_in;
      hold_rd  <= rd_in;
      hold_rw  <= reg_wr_in;
    end
  end

  assign busy     = (state_q == MUL);
  assign mul_emit = (state_q == MUL) && mul_done && !flush_in;
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  // EX/MEM next value: bubble unless a single-cycle op is accepted or a
  // multiply completes.
  always_comb begin
    v_d   = 1'b0;
    res_d = '0;
    imm_d = '0;
    pc_d  = '0;
    sd_d  = '0;
    mem_d = '0;
    rd_d  = '0;
    rw_d  = 1'b0;
    c_d   = 1'b0;
    if (accept && !is_mul) begin
      v_d   = 1'b1;
      res_d = alu_res;
      imm_d = imm_in;
      pc_d  = pc_in;
      sd_d  = store_data_in;
      mem_d = mem_signals_in;
      rd_d  = rd_in;
      rw_d  = reg_wr_in;
      c_d   = alu_carry;
    end
`ifdef EX_MUL_EN
    else if (mul_emit) begin
      v_d   = 1'b1;
      res_d = mul_product[WIDTH-1:0];
      imm_d = hold_imm;
      pc_d  = hold_pc;
      sd_d  = hold_sd;
      mem_d = hold_mem;
      rd_d  = hold_rd;
      rw_d  = hold_rw;
      c_d   = |mul_product[2*WIDTH-1:WIDTH];
    end
`endif
    z_d = v_d && (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      alu_result  <= '0;
      imm_out     <= '0;
      pc_out      <= '0;
      store_data  <= '0;
      mem_signals <= '0;
      rd_out      <= '0;
      reg_wr_out  <= 1'b0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
    end else begin
      valid_out   <= v_d;
      alu_result  <= res_d;
      imm_out     <= imm_d;
      pc_out      <= pc_d;
      store_data  <= sd_d;
      mem_signals <= mem_d;
      rd_out      <= rd_d;
      reg_wr_out  <= rw_d;
      zero_flag   <= z_d;
      carry_flag  <= c_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios then random traffic,
// every cycle compared against a transaction-level model of the stage.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int W = 16;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, valid_in, flush_in, reg_wr_in;
  logic [2:0]   alu_op, rd_in;
  logic [W-1:0] op_a, op_b, imm_in, pc_in, store_data_in;
  logic [6:0]   mem_signals_in;
  logic         busy, valid_out, reg_wr_out, zero_flag, carry_flag;
  logic [W-1:0] alu_result, imm_out, pc_out, store_data;
  logic [6:0]   mem_signals;
  logic [2:0]   rd_out;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush_in(flush_in),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .imm_in(imm_in), .pc_in(pc_in),
    .store_data_in(store_data_in), .mem_signals_in(mem_signals_in),
    .rd_in(rd_in), .reg_wr_in(reg_wr_in), .busy(busy), .valid_out(valid_out),
    .alu_result(alu_result), .imm_out(imm_out), .pc_out(pc_out),
    .store_data(store_data), .mem_signals(mem_signals), .rd_out(rd_out),
    .reg_wr_out(reg_wr_out), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  typedef struct packed {
    logic       rst_n, valid, flush;
    logic [2:0] op;
    logic [15:0] a, b, imm, pc, sd;
    logic [6:0] mem;
    logic [2:0] rd;
    logic       rw;
  } stim_t;

  typedef struct packed {
    logic        v;
    logic [15:0] res, imm, pc, sd;
    logic [6:0]  mem;
    logic [2:0]  rd;
    logic        rw, z, c;
  } out_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   mul_left = 0;
  out_t pend = '0;
  out_t expo = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Architectural result of one instruction, straight from the arithmetic rules.
  function automatic out_t execute(input stim_t s);
    out_t o = '0;
    longint unsigned a = s.a;
    longint unsigned b = s.b;
    longint unsigned r = 0;
    logic cy = 1'b0;
    case (s.op)
      3'd0: r = a & b;
      3'd1: begin r = a + b; cy = (r > 65535); end
      3'd2: begin r = a + 65536 - b; cy = (a < b); end
      3'd3: r = a | b;
      3'd4: r = a << (b % 16);
      3'd5: r = a >> (b % 16);
      3'd6: if (MUL_EN) begin r = a * b; cy = ((r >> 16) != 0); end
            else r = 0;
      default: r = b;
    endcase
    o.v   = 1'b1;
    o.res = r[15:0];
    o.imm = s.imm;
    o.pc  = s.pc;
    o.sd  = s.sd;
    o.mem = s.mem;
    o.rd  = s.rd;
    o.rw  = s.rw;
    o.c   = cy;
    o.z   = (r[15:0] == 16'h0000);
    return o;
  endfunction

  // Expected EX/MEM contents after one edge; mul_left counts cycles until the product.
  task automatic model(input stim_t s);
    if (!s.rst_n) begin
      mul_left = 0;
      expo     = '0;
    end else if (mul_left > 0) begin
      if (s.flush) begin
        mul_left = 0;
        expo     = '0;
      end else begin
        mul_left--;
        expo = (mul_left == 0) ? pend : '0;
      end
    end else if (s.valid && !s.flush) begin
      if (s.op == 3'd6 && MUL_EN) begin
        pend     = execute(s);
        mul_left = W;
        expo     = '0;
      end else begin
        expo = execute(s);
      end
    end else begin
      expo = '0;
    end
  endtask

  task automatic compare(input string ctx);
    check({ctx, ".valid"}, valid_out, expo.v);
    check({ctx, ".res"},   alu_result, expo.res);
    check({ctx, ".imm"},   imm_out, expo.imm);
    check({ctx, ".pc"},    pc_out, expo.pc);
    check({ctx, ".sd"},    store_data, expo.sd);
    check({ctx, ".mem"},   mem_signals, expo.mem);
    check({ctx, ".rd"},    rd_out, expo.rd);
    check({ctx, ".rw"},    reg_wr_out, expo.rw);
    check({ctx, ".zero"},  zero_flag, expo.z);
    check({ctx, ".carry"}, carry_flag, expo.c);
    check({ctx, ".busy"},  busy, (mul_left > 0));
  endtask

  task automatic step(input stim_t s, input string ctx);
    rst_n          = s.rst_n;
    valid_in       = s.valid;
    flush_in       = s.flush;
    alu_op         = s.op;
    op_a           = s.a;
    op_b           = s.b;
    imm_in         = s.imm;
    pc_in          = s.pc;
    store_data_in  = s.sd;
    mem_signals_in = s.mem;
    rd_in          = s.rd;
    reg_wr_in      = s.rw;
    @(posedge clk);
    model(s);
    @(negedge clk);
    compare(ctx);
  endtask

  function automatic stim_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    stim_t s;
    s.rst_n = 1'b1;
    s.valid = 1'b1;
    s.flush = 1'b0;
    s.op    = op;
    s.a     = a;
    s.b     = b;
    s.imm   = 16'($urandom);
    s.pc    = 16'($urandom);
    s.sd    = 16'($urandom);
    s.mem   = 7'($urandom);
    s.rd    = 3'($urandom);
    s.rw    = 1'($urandom);
    return s;
  endfunction

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'($urandom_range(0, 15));
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    stim_t s;
    int    n_valid;

    // Reset held with a valid instruction presented.
    s = mk(ALU_ADD, 16'h1234, 16'h1111);
    s.rst_n = 1'b0;
    step(s, "reset0");
    step(s, "reset1");

    step(mk(ALU_ADD, 16'h7FFF, 16'h0001), "add");
    check("add_direct", alu_result, 16'h8000);
    step(mk(ALU_SUB, 16'h0003, 16'h0005), "sub");
    check("sub_direct", {carry_flag, alu_result}, 17'h1FFFE);
    step(mk(ALU_AND, 16'h00F0, 16'h0F00), "and");
    check("and_zero", zero_flag, 1'b1);
    step(mk(ALU_SLL, 16'h0001, 16'h0013), "sll");
    check("sll_direct", alu_result, 16'h0008);
    step(mk(ALU_SRL, 16'h8000, 16'h000F), "srl");
    step(mk(ALU_PASSB, 16'h1234, 16'hBEEF), "passb");

    // MUL with an ADD waiting behind it for the whole busy window.
    step(mk(ALU_MUL, 16'h0100, 16'h0100), "mul256");
    n_valid = 0;
    s = mk(ALU_ADD, 16'h0001, 16'h0002);
    for (int i = 0; i < 17; i++) begin
      step(s, "mul256_wait");
      n_valid += int'(valid_out);
    end
    check("mul256_add_once", n_valid, MUL_EN ? 2 : 17);
    s.valid = 1'b0;
    step(s, "idle0");

    // MUL aborted by flush part-way through, then a normal OR.
    step(mk(ALU_MUL, 16'h0012, 16'h0034), "mulflush");
    s = mk(ALU_OR, 16'h0000, 16'h0000);
    s.valid = 1'b0;
    for (int i = 0; i < 7; i++) step(s, "mulflush_run");
    s.flush = 1'b1;
    step(s, "mulflush_kill");
    step(mk(ALU_OR, 16'h0F0F, 16'h3000), "or_after");
    s.flush = 1'b0;
    for (int i = 0; i < 18; i++) step(s, "mulflush_quiet");

    // Control fields: killed by flush, then registered unchanged.
    s = mk(ALU_ADD, 16'h0010, 16'h0020);
    s.mem = 7'b1110110;
    s.rd  = 3'd5;
    s.rw  = 1'b1;
    s.flush = 1'b1;
    step(s, "ctl_flush");
    s.flush = 1'b0;
    step(s, "ctl_pass");
    check("ctl_mem", mem_signals, 7'b1110110);
    check("ctl_rd", rd_out, 3'd5);

    // Small MUL, then reset in the middle of another one.
    step(mk(ALU_MUL, 16'h0003, 16'h0004), "mul3x4");
    s.valid = 1'b0;
    for (int i = 0; i < 17; i++) step(s, "mul3x4_run");
    step(mk(ALU_MUL, 16'hFFFF, 16'hFFFF), "mulrst");
    for (int i = 0; i < 5; i++) step(s, "mulrst_run");
    s.rst_n = 1'b0;
    step(s, "mulrst_reset");
    s.rst_n = 1'b1;
    for (int i = 0; i < 18; i++) step(s, "mulrst_quiet");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      s = mk(3'($urandom), rand_word(), rand_word());
      s.valid = ($urandom_range(0, 99) < 75);
      s.flush = ($urandom_range(0, 99) < 6);
      s.rst_n = ($urandom_range(0, 199) != 0);
      step(s, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipeline: performs the ALU operation on operands from the ID/EX side and registers the EX/MEM boundary that feeds the memory stage (ALU result, immediate, PC, store data, 7-bit memory/writeback control). Single-cycle ops complete in one clock. MUL runs on an iterative shift-add unit, which holds the upstream pipeline through `busy` and inserts bubbles downstream until the product is ready.

## Interface
- `WIDTH`, 16, datapath width; the multiplier runs `WIDTH` iterations.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low; one clock, synchronous reset, active-low.
- `valid_in`  in  1  ID/EX holds a valid instruction.
- `flush_in`  in  1  kill the current/in-flight instruction (branch redirect).
- `alu_op`  in  3  0 AND, 1 ADD, 2 SUB, 3 OR, 4 SLL, 5 SRL, 6 MUL, 7 PASSB.
- `op_a`, `op_b`  in  WIDTH  source operands, already forwarded.
- `imm_in`, `pc_in`, `store_data_in`  in  WIDTH  passed to the MEM side.
- `mem_signals_in`  in  7  {DataInSrc, MemRd, MemWr, NumOfByte[1:0], WBdata[1:0]}.
- `rd_in`  in  3  destination register.
- `reg_wr_in`  in  1  register write enable.
- `busy`  out  1  multiplier active; ID/EX must hold its contents.
- `valid_out`  out  1  EX/MEM holds a real instruction.
- `alu_result`, `imm_out`, `pc_out`, `store_data`  out  WIDTH  registered EX/MEM fields.
- `mem_signals`  out  7  registered control; all zero on a bubble.
- `rd_out`  out  3  registered destination register.
- `reg_wr_out`  out  1  registered write enable; zero on a bubble.
- `zero_flag`, `carry_flag`  out  1  registered flags of `alu_result`.

## Operation
- Accept: `valid_in && !busy && !flush_in` at a rising edge.
- Bubble: all outputs zero (`valid_out`=0, `mem_signals`=0, `reg_wr_out`=0).
- States: IDLE, MUL.
- IDLE, accepted non-MUL op: EX/MEM is loaded at the same edge.
- IDLE, accepted MUL:
  - Operands, `rd`, control and pass-through fields are latched internally.
  - Iteration counter is cleared; state goes to MUL; EX/MEM gets a bubble.
- MUL:
  - Each edge performs one shift-add step; EX/MEM gets a bubble.
  - At the `WIDTH`-th step, EX/MEM is loaded with the product low half and the latched fields, then state returns to IDLE.
- Inputs are ignored while in MUL.
- Flush: has priority over acceptance and over MUL completion. At that edge EX/MEM gets a bubble, state goes to IDLE, and the counter is cleared.
- `valid_in`=0 in IDLE gives a bubble.
- Arithmetic (unsigned, `WIDTH` bits):
  - ADD: carry = bit `WIDTH` of the sum.
  - SUB: `op_a-op_b`; carry = borrow (`op_a<op_b`).
  - SLL/SRL: shift by `op_b[3:0]`, zero fill; carry 0.
  - AND/OR/PASSB: carry 0.
  - MUL: result = low half of the product; carry = OR of the high half.
- `zero_flag` = (result == 0) for valid instructions; 0 on a bubble.

## Timing
- Reset: state IDLE, `busy`=0, every output 0.
- Reset mid-MUL aborts the operation; no result is emitted.
- Non-MUL latency: 1 cycle; throughput 1 per cycle.
- MUL accepted at edge E0:
  - `busy`=1 from E0 until E`WIDTH`, i.e. exactly `WIDTH` cycles.
  - Result is valid after E`WIDTH`.
  - The next instruction is accepted at E`WIDTH`+1 at the earliest.
- `busy` is a registered output equal to (state==MUL). No combinational path from inputs to outputs.

## Configuration
- `EX_MUL_EN` defined: multiplier, FSM and `busy` are as above.
- `EX_MUL_EN` not defined:
  - FSM and multiplier are not built; `busy` is tied to 0.
  - `alu_op`=6 completes in one cycle with result 0x0000, carry 0, zero_flag 1, control passed through unchanged.

## Structure
- Package `ex_pkg` holds:
  - `alu_op_t` enum.
  - `ex_state_t` {IDLE, MUL}.
  - Bit indices of the 7-bit memory signal vector.
  - WBdata encodings (0 PC, 1 ALU, 2 memory).
- Sub-module `seq_multiplier` (start, operands, done, product), instantiated under `EX_MUL_EN`.

## Test plan
- Reset held with `valid_in`=1 → all outputs 0, `busy`=0; after release, ADD 0x7FFF+0x0001 → next cycle `alu_result`=0x8000, carry 0, `valid_out`=1.
- SUB 0x0003-0x0005 → 0xFFFE, carry 1; AND 0x00F0&0x0F00 → 0x0000, zero_flag 1; SLL 0x0001 by 0x0013 → 0x0008.
- MUL 0x0100×0x0100 → `busy` high 16 cycles with bubbles, then result 0x0000, carry 1, zero 1; a following ADD presented throughout is accepted only after `busy` falls and appears exactly once.
- MUL 0x0012×0x0034 with `flush_in` pulsed at cycle 8 → no result emitted, `busy` drops next cycle, a subsequent OR completes normally.
- `mem_signals_in`=7'b1110110, `rd_in`=5, accepted with `flush_in`=1 → bubble (all zero); same inputs without flush → fields registered unchanged.
- Without `EX_MUL_EN`: MUL 0x0003×0x0004 → one cycle, result 0x0000, `busy` never asserts.
